// File: rtl/alu_pkg.sv
// Shared definitions for the 1-bit ALU slice: control codes and the control type.
package alu_pkg;

  typedef logic [3:0] alu_ctrl_t;

  // Control layout is {ainvert, bnegate, op[1:0]}.
  localparam alu_ctrl_t ALU_AND = 4'b0000;
  localparam alu_ctrl_t ALU_OR  = 4'b0001;
  localparam alu_ctrl_t ALU_ADD = 4'b0010;
  localparam alu_ctrl_t ALU_SUB = 4'b0110;
  localparam alu_ctrl_t ALU_SLT = 4'b0111;
  localparam alu_ctrl_t ALU_NOR = 4'b1100;

endpackage

// File: rtl/full_adder_1b.sv
// Purely combinational 1-bit full adder, shared with wider ripple ALUs.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and majority carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/alu_1bit.sv
// Single-bit ALU slice with registered result and carry out.
//
// Interface timing: there is no handshake and no enable. The inputs are
// sampled at every rising clk edge, and result/cout show the value for those
// inputs one cycle later. The outputs hold until the next edge.
module alu_1bit
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       binvert,
  input  logic [3:0] control,
  output logic       result,
  output logic       cout
);

  alu_ctrl_t ctrl;
  logic      a_eff;
  logic      b_eff;
  logic      cin;
  logic      fa_sum;
  logic      fa_cout;
  logic      result_d;
  logic      result_q;
  logic      cout_d;
  logic      cout_q;

  // Arithmetic operands. binvert alone inverts B and supplies the carry-in.
  // control[2] only takes part in the decode match below.
  always_comb begin
    ctrl  = control;
    a_eff = a ^ ctrl[3];
    b_eff = b ^ binvert;
    cin   = binvert;
  end

  full_adder_1b u_fa (
    .a    (a_eff),
    .b    (b_eff),
    .cin  (cin),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Decode on the full control code. Logic ops use the raw operands.
  // Arithmetic ops use the adder. SLT is the borrow of a-b, which is the
  // inverted carry of a + ~b + 1. Unlisted codes produce zeros.
  always_comb begin
    result_d = 1'b0;
    cout_d   = 1'b0;
    case (ctrl)
      ALU_AND: result_d = a & b;
      ALU_OR:  result_d = a | b;
      ALU_NOR: result_d = ~(a | b);
      ALU_ADD: begin
        result_d = fa_sum;
        cout_d   = fa_cout;
      end
      ALU_SUB: begin
        result_d = fa_sum;
        cout_d   = fa_cout;
      end
      ALU_SLT: result_d = ~fa_cout;
      default: begin
        result_d = 1'b0;
        cout_d   = 1'b0;
      end
    endcase
  end

  // Output register. Reset takes priority and drops whatever was being computed.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_alu_1bit.sv
// Bench for alu_1bit: directed and random stimulus against a reference model.
// A scoreboard queue feeds a monitor that checks the outputs.
module tb_alu_1bit;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       binvert;
  logic [3:0] control;
  logic       result;
  logic       cout;

  logic [1:0] exp_q[$];
  string      name_q[$];
  int         checks;
  int         errors;

  alu_1bit dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .binvert (binvert),
    .control (control),
    .result  (result),
    .cout    (cout)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst     = 1'b1;
    a       = 1'b0;
    b       = 1'b0;
    binvert = 1'b0;
    control = 4'b0000;
  end

  // Reference model. Arithmetic is done with integer addition.
  // Returns {result, cout}.
  function automatic logic [1:0] model(input logic ma, input logic mb,
                                       input logic [3:0] mc, input logic mrst);
    int s;
    if (mrst) return 2'b00;
    case (mc)
      4'b0000: return {ma & mb, 1'b0};
      4'b0001: return {ma | mb, 1'b0};
      4'b1100: return {~(ma | mb), 1'b0};
      4'b0010: begin
        s = int'(ma) + int'(mb);
        return {s[0], s[1]};
      end
      4'b0110: begin
        s = int'(ma) + (1 - int'(mb)) + 1;
        return {s[0], s[1]};
      end
      4'b0111: return {(int'(ma) < int'(mb)), 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  // Driver: apply inputs on the falling edge, then record the expected
  // response once the rising edge has captured them.
  task automatic drive(input logic da, input logic db, input logic [3:0] dc,
                       input logic dbinv, input logic drst, input string tag);
    @(negedge clk);
    a       = da;
    b       = db;
    control = dc;
    binvert = dbinv;
    rst     = drst;
    @(posedge clk);
    exp_q.push_back(model(da, db, dc, drst));
    name_q.push_back(tag);
  endtask

  // Operation with binvert tied to control[2], as users wire it.
  task automatic op(input logic da, input logic db, input logic [3:0] dc, input string tag);
    drive(da, db, dc, dc[2], 1'b0, tag);
  endtask

  // Monitor: each falling edge shows the response to the previous rising edge.
  initial begin
    logic [1:0] exp;
    string      tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tag = name_q.pop_front();
        checks++;
        if ({result, cout} !== exp) begin
          errors++;
          $display("FAIL %s: got result=%b cout=%b, expected result=%b cout=%b",
                   tag, result, cout, exp[1], exp[0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0] codes[6];
    logic [3:0] c;
    int         wait_cycles;
    checks = 0;
    errors = 0;
    codes[0] = 4'b0000;
    codes[1] = 4'b0001;
    codes[2] = 4'b1100;
    codes[3] = 4'b0010;
    codes[4] = 4'b0110;
    codes[5] = 4'b0111;

    // Reset held with OR of 1,1 pending, then released.
    drive(1'b1, 1'b1, 4'b0001, 1'b0, 1'b1, "reset_0");
    drive(1'b1, 1'b1, 4'b0001, 1'b0, 1'b1, "reset_1");
    drive(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, "reset_release_or");

    // Full sweeps of every legal code over all operand pairs.
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 4; p++) begin
        op(p[1], p[0], codes[k], $sformatf("sweep_c%b_ab%0d%0d", codes[k], p[1], p[0]));
      end
    end

    // Illegal code and a reset landing on an ADD that would carry.
    drive(1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, "illegal_1111");
    op(1'b1, 1'b1, 4'b0010, "add_11_before_reset");
    drive(1'b1, 1'b1, 4'b0010, 1'b0, 1'b1, "add_11_under_reset");
    op(1'b1, 1'b1, 4'b0010, "add_11_after_reset");

    // Back-to-back different codes.
    op(1'b0, 1'b1, 4'b0110, "b2b_sub");
    op(1'b0, 1'b1, 4'b0111, "b2b_slt");
    op(1'b1, 1'b1, 4'b0010, "b2b_add");
    op(1'b0, 1'b0, 4'b1100, "b2b_nor");
    op(1'b1, 1'b0, 4'b0000, "b2b_and");

    // Random ops, with occasional illegal codes and resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) c = 4'($urandom_range(0, 15));
      else c = codes[$urandom_range(0, 5)];
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c, c[2],
            ($urandom_range(0, 15) == 0), $sformatf("rand_%0d", i));
    end

    // Drain with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
    end

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
